// File: rtl/fxp_mac_accum.sv
// rtl/fxp_mac_accum.sv - streaming fixed-point multiply-accumulate with rounding/saturation
// Two-stage pipeline: exact product register, then guarded accumulate and per-vector quantization.
module fxp_mac_accum #(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int GUARD = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                   rstn,
  input  logic                   clk,
  input  logic                   i_en,
  input  logic                   i_last,
  input  logic [WIIA+WIFA-1:0]   ina,
  input  logic [WIIB+WIFB-1:0]   inb,
  output logic                   o_en,
  output logic [WOI+WOF-1:0]     out,
  output logic                   upflow,
  output logic                   downflow
);

  localparam int PF   = WIFA + WIFB;
  localparam int PW   = WIIA + WIIB + PF;
  localparam int AW   = WIIA + WIIB + GUARD + PF;
  localparam int OW   = WOI + WOF;
  localparam int LSH  = (WOF >= PF) ? WOF - PF : 0;
  localparam int RSH  = (WOF < PF) ? PF - WOF : 0;
  localparam int RSH1 = (RSH > 0) ? RSH - 1 : 0;
  // Wide enough for the left shift, the rounding carry and the OW-bit range test.
  localparam int QW   = AW + 2 + LSH + OW;

  localparam logic signed [QW-1:0] HALF    = QW'(1) << RSH1;
  localparam logic signed [QW-1:0] HALF_M1 = HALF - QW'(1);
  localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [PW-1:0] p_q;
  logic                 p_en;
  logic                 p_last;

  logic signed [AW-1:0] acc;
  logic                 acc_ovf;
  logic                 first;

  logic signed [AW-1:0] acc_base;
  logic signed [AW:0]   sum_w;
  logic                 sum_ovf;
  logic signed [AW-1:0] sum_c;

  logic signed [QW-1:0] q_ext;
  logic signed [QW-1:0] q_rnd;
  logic signed [QW-1:0] q_val;
  logic                 q_fit;
  logic                 q_up;
  logic                 q_down;
  logic [OW-1:0]        q_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q    <= '0;
      p_en   <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_en   <= i_en;
      p_last <= i_en & i_last;
      if (i_en) begin
        p_q <= PW'($signed(ina)) * PW'($signed(inb));
      end
    end
  end

  assign acc_base = first ? '0 : acc;
  assign sum_w    = (AW+1)'(acc_base) + (AW+1)'(p_q);
  assign sum_ovf  = sum_w[AW] ^ sum_w[AW-1];
  assign sum_c    = sum_ovf ? (sum_w[AW] ? ACC_MIN : ACC_MAX) : sum_w[AW-1:0];

  // Rounding bias: +half for positive, +half-1 for negative, so the floor shift rounds ties away from zero.
  always_comb begin
    q_ext = QW'(sum_c) <<< LSH;
    q_rnd = q_ext;
    if (ROUND != 0 && RSH > 0) begin
      q_rnd = q_ext + (q_ext[QW-1] ? HALF_M1 : HALF);
    end
    q_val = q_rnd >>> RSH;
    q_fit = (q_val[QW-1:OW-1] == '0) || (q_val[QW-1:OW-1] == '1);
    q_up  = !q_fit || acc_ovf || sum_ovf;
    q_out = q_val[OW-1:0];
    if (q_up && ROOF != 0) begin
      q_out = sum_c[AW-1] ? OUT_MIN : OUT_MAX;
    end
    q_down = (sum_c != '0) && (q_out == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      first    <= 1'b1;
      o_en     <= 1'b0;
      out      <= '0;
      upflow   <= 1'b0;
      downflow <= 1'b0;
    end else begin
      o_en <= p_en & p_last;
      if (p_en) begin
        if (p_last) begin
          out      <= q_out;
          upflow   <= q_up;
          downflow <= q_down;
          first    <= 1'b1;
          acc_ovf  <= 1'b0;
        end else begin
          acc     <= sum_c;
          acc_ovf <= acc_ovf | sum_ovf;
          first   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fxp_mac_accum.sv
// tb/tb_fxp_mac_accum.sv - scoreboard bench for fxp_mac_accum at default 8.8 formats
module tb_fxp_mac_accum;

  logic        rstn;
  logic        clk;
  logic        i_en;
  logic        i_last;
  logic [15:0] ina;
  logic [15:0] inb;
  logic        o_en;
  logic [15:0] out;
  logic        upflow;
  logic        downflow;

  typedef struct {
    logic [15:0] out;
    logic        up;
    logic        down;
    int          cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp;
  int     n_bad;
  int     cyc;
  longint model_acc;
  bit     model_ovf;

  fxp_mac_accum dut (
    .rstn(rstn), .clk(clk), .i_en(i_en), .i_last(i_last), .ina(ina), .inb(inb),
    .o_en(o_en), .out(out), .upflow(upflow), .downflow(downflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t quant(input longint s, input bit ovf, input int c);
    exp_t   e;
    longint q;
    if (s >= 0) q = (s + 128) >>> 8;
    else        q = -((-s + 128) >>> 8);
    e.up = ovf || (q > 32767) || (q < -32768);
    if (e.up) q = (s < 0) ? -32768 : 32767;
    e.out  = q[15:0];
    e.down = (s != 0) && (e.out == 16'h0000);
    e.cyc  = c;
    return e;
  endfunction

  task automatic term(input logic [15:0] a, input logic [15:0] b, input bit last);
    longint p;
    @(posedge clk);
    #1;
    i_en = 1'b1; ina = a; inb = b; i_last = last;
    p = longint'($signed(a)) * longint'($signed(b));
    model_acc = model_acc + p;
    if (model_acc > 64'sd549755813887) begin
      model_acc = 64'sd549755813887; model_ovf = 1'b1;
    end else if (model_acc < -64'sd549755813888) begin
      model_acc = -64'sd549755813888; model_ovf = 1'b1;
    end
    if (last) begin
      sb.push_back(quant(model_acc, model_ovf, cyc + 2));
      model_acc = 0;
      model_ovf = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      i_en = 1'b0; ina = 16'($urandom); inb = 16'($urandom); i_last = 1'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && o_en) begin
      if (sb.size() == 0) begin
        chk("spurious_o_en", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", out, e.out);
        chk("upflow", upflow, e.up);
        chk("downflow", downflow, e.down);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; model_acc = 0; model_ovf = 1'b0;
    rstn = 1'b0; i_en = 1'b0; i_last = 1'b0; ina = '0; inb = '0;
    #23;
    chk("rst_o_en", o_en, 0);
    chk("rst_out", out, 0);
    chk("rst_upflow", upflow, 0);
    chk("rst_downflow", downflow, 0);
    @(negedge clk);
    rstn = 1'b1;

    term(16'h0180, 16'h0200, 1'b1);
    idle(4);

    term(16'h0100, 16'h0100, 1'b0);
    term(16'h0200, 16'hFF80, 1'b0);
    term(16'h0040, 16'h0400, 1'b0);
    term(16'hFD00, 16'h0100, 1'b1);
    term(16'h0100, 16'h0100, 1'b1);
    idle(4);

    for (int k = 0; k < 16; k++) term(16'h7F00, 16'h0100, k == 15);
    term(16'h8000, 16'h0100, 1'b0);
    term(16'h8000, 16'h0100, 1'b1);
    idle(3);

    term(16'h0001, 16'h0080, 1'b1);
    term(16'hFFFF, 16'h0080, 1'b1);
    term(16'h0001, 16'h0040, 1'b1);
    idle(4);

    term(16'h0100, 16'h0100, 1'b0);
    idle($urandom_range(1, 3));
    term(16'h0200, 16'hFF80, 1'b0);
    idle($urandom_range(1, 3));
    term(16'h0040, 16'h0400, 1'b0);
    idle($urandom_range(1, 3));
    term(16'hFD00, 16'h0100, 1'b1);
    idle(4);
    chk("hold_out", out, 16'hFE00);

    term(16'h0100, 16'h0100, 1'b0);
    term(16'h0100, 16'h0100, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0; i_en = 1'b0;
    model_acc = 0; model_ovf = 1'b0;
    #1;
    chk("async_rst_o_en", o_en, 0);
    chk("async_rst_out", out, 0);
    chk("async_rst_upflow", upflow, 0);
    chk("async_rst_downflow", downflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    term(16'h0100, 16'h0100, 1'b1);
    idle(1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("missing_o_en", 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
